// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded ID state, inserts bubbles on flush,
// holds on stall, and keeps saturating bubble/hold counters for performance debug.
module id_ex_pipe_reg #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_ex_en,
  input  logic             id_ex_flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [6:0]       id_opcode,
  input  logic [2:0]       id_func3,
  input  logic             id_func7_b5,
  input  logic [9:0]       id_ctrl,
  input  logic             id_pred_taken,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [6:0]       ex_opcode,
  output logic [2:0]       ex_func3,
  output logic             ex_func7_b5,
  output logic [9:0]       ex_ctrl,
  output logic             ex_load_inst,
  output logic             ex_pred_taken,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] hold_cnt
);

  // Control packing: {reg_write,mem_read,mem_write,mem_to_reg,alu_src,branch,jump,alu_op[2:0]}
  localparam int unsigned CtrlRegWrite = 9;
  localparam int unsigned CtrlMemRead  = 8;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic            func7_b5;
    logic [9:0]      ctrl;
    logic            pred_taken;
  } stage_t;

  stage_t stage_d, stage_q, id_stage;

  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic [CNT_W-1:0] hold_cnt_d, hold_cnt_q;

  // Assemble the incoming ID state; invalid slots carry no control side effects.
  always_comb begin
    id_stage            = '0;
    id_stage.valid      = id_valid;
    id_stage.pc         = id_pc;
    id_stage.rs1_data   = id_rs1_data;
    id_stage.rs2_data   = id_rs2_data;
    id_stage.imm        = id_imm;
    id_stage.rs1        = id_rs1;
    id_stage.rs2        = id_rs2;
    id_stage.rd         = id_rd;
    id_stage.opcode     = id_opcode;
    id_stage.func3      = id_func3;
    id_stage.func7_b5   = id_func7_b5;
    id_stage.ctrl       = id_valid ? id_ctrl : '0;
    id_stage.pred_taken = id_valid ? id_pred_taken : 1'b0;
    // Writes to x0 are dropped here so later stages never see them.
    if (id_rd == 5'd0) begin
      id_stage.ctrl[CtrlRegWrite] = 1'b0;
    end
  end

  // Next stage state: flush beats capture beats hold.
  always_comb begin
    stage_d = stage_q;
    if (id_ex_flush) begin
      stage_d = '0;
    end else if (id_ex_en) begin
      stage_d = id_stage;
    end
  end

  // Saturating performance counters.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    if (id_ex_flush && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
    if (!id_ex_en && !id_ex_flush && (hold_cnt_q != {CNT_W{1'b1}})) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q      <= '0;
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      stage_q      <= stage_d;
      bubble_cnt_q <= bubble_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  // All outputs come straight from flops.
  always_comb begin
    ex_valid      = stage_q.valid;
    ex_pc         = stage_q.pc;
    ex_rs1_data   = stage_q.rs1_data;
    ex_rs2_data   = stage_q.rs2_data;
    ex_imm        = stage_q.imm;
    ex_rs1        = stage_q.rs1;
    ex_rs2        = stage_q.rs2;
    ex_rd         = stage_q.rd;
    ex_opcode     = stage_q.opcode;
    ex_func3      = stage_q.func3;
    ex_func7_b5   = stage_q.func7_b5;
    ex_ctrl       = stage_q.ctrl;
    ex_load_inst  = stage_q.ctrl[CtrlMemRead];
    ex_pred_taken = stage_q.pred_taken;
    bubble_cnt    = bubble_cnt_q;
    hold_cnt      = hold_cnt_q;
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg (default width plus a CNT_W=4 copy).
module tb_id_ex_pipe_reg;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst;
  logic            id_ex_en;
  logic            id_ex_flush;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [6:0]      id_opcode;
  logic [2:0]      id_func3;
  logic            id_func7_b5;
  logic [9:0]      id_ctrl;
  logic            id_pred_taken;

  logic            ex_valid, ex_func7_b5, ex_load_inst, ex_pred_taken;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_func3;
  logic [9:0]      ex_ctrl;
  logic [15:0]     bubble_cnt, hold_cnt;

  logic            s_valid, s_func7_b5, s_load_inst, s_pred_taken;
  logic [XLEN-1:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0]      s_rs1, s_rs2, s_rd;
  logic [6:0]      s_opcode;
  logic [2:0]      s_func3;
  logic [9:0]      s_ctrl;
  logic [3:0]      s_bubble_cnt, s_hold_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_pipe_reg u_dut (
    .clk(clk), .rst(rst), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_opcode(id_opcode), .id_func3(id_func3),
    .id_func7_b5(id_func7_b5), .id_ctrl(id_ctrl), .id_pred_taken(id_pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_func3(ex_func3),
    .ex_func7_b5(ex_func7_b5), .ex_ctrl(ex_ctrl), .ex_load_inst(ex_load_inst),
    .ex_pred_taken(ex_pred_taken), .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
  );

  id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(4)) u_dut_sat (
    .clk(clk), .rst(rst), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_opcode(id_opcode), .id_func3(id_func3),
    .id_func7_b5(id_func7_b5), .id_ctrl(id_ctrl), .id_pred_taken(id_pred_taken),
    .ex_valid(s_valid), .ex_pc(s_pc), .ex_rs1_data(s_rs1_data),
    .ex_rs2_data(s_rs2_data), .ex_imm(s_imm), .ex_rs1(s_rs1), .ex_rs2(s_rs2),
    .ex_rd(s_rd), .ex_opcode(s_opcode), .ex_func3(s_func3),
    .ex_func7_b5(s_func7_b5), .ex_ctrl(s_ctrl), .ex_load_inst(s_load_inst),
    .ex_pred_taken(s_pred_taken), .bubble_cnt(s_bubble_cnt), .hold_cnt(s_hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one ID instruction; other fields are derived from pc so they vary per vector.
  task automatic drive_id(input logic valid, input logic [31:0] pc, input logic [4:0] rd,
                          input logic [9:0] ctrl, input logic pred);
    id_valid      = valid;
    id_pc         = pc;
    id_rs1_data   = pc ^ 32'hA5A5_0000;
    id_rs2_data   = pc ^ 32'h0000_5A5A;
    id_imm        = pc + 32'h10;
    id_rs1        = 5'd1;
    id_rs2        = 5'd2;
    id_rd         = rd;
    id_opcode     = 7'h33;
    id_func3      = pc[4:2];
    id_func7_b5   = 1'b1;
    id_ctrl       = ctrl;
    id_pred_taken = pred;
  endtask

  // Advance one rising edge; return at the following falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, {63'd0, ex_valid}, 64'd0);
    check_eq({tag, "_pc"}, {32'd0, ex_pc}, 64'd0);
    check_eq({tag, "_rs1d"}, {32'd0, ex_rs1_data}, 64'd0);
    check_eq({tag, "_imm"}, {32'd0, ex_imm}, 64'd0);
    check_eq({tag, "_rd"}, {59'd0, ex_rd}, 64'd0);
    check_eq({tag, "_opc"}, {57'd0, ex_opcode}, 64'd0);
    check_eq({tag, "_ctrl"}, {54'd0, ex_ctrl}, 64'd0);
    check_eq({tag, "_load"}, {63'd0, ex_load_inst}, 64'd0);
    check_eq({tag, "_pred"}, {63'd0, ex_pred_taken}, 64'd0);
  endtask

  initial begin
    rst         = 1'b1;
    id_ex_en    = 1'b1;
    id_ex_flush = 1'b0;
    drive_id(1'b1, 32'h0000_0050, 5'd9, 10'h3FF, 1'b1);
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check_all_zero("rst");
    check_eq("rst_bubble", {48'd0, bubble_cnt}, 64'd0);
    check_eq("rst_hold", {48'd0, hold_cnt}, 64'd0);

    // Plain capture: R-type with reg_write, rd=5
    rst = 1'b0;
    drive_id(1'b1, 32'h0000_0100, 5'd5, 10'h203, 1'b1);
    step();
    check_eq("cap_pc", {32'd0, ex_pc}, 64'h100);
    check_eq("cap_rd", {59'd0, ex_rd}, 64'd5);
    check_eq("cap_valid", {63'd0, ex_valid}, 64'd1);
    check_eq("cap_ctrl", {54'd0, ex_ctrl}, 64'h203);
    check_eq("cap_rs1d", {32'd0, ex_rs1_data}, 64'hA5A5_0100);
    check_eq("cap_rs2d", {32'd0, ex_rs2_data}, 64'h0000_5B5A);
    check_eq("cap_imm", {32'd0, ex_imm}, 64'h110);
    check_eq("cap_rs1", {59'd0, ex_rs1}, 64'd1);
    check_eq("cap_rs2", {59'd0, ex_rs2}, 64'd2);
    check_eq("cap_opc", {57'd0, ex_opcode}, 64'h33);
    check_eq("cap_f3", {61'd0, ex_func3}, 64'd0);
    check_eq("cap_f7", {63'd0, ex_func7_b5}, 64'd1);
    check_eq("cap_pred", {63'd0, ex_pred_taken}, 64'd1);
    check_eq("cap_load", {63'd0, ex_load_inst}, 64'd0);

    // x0 guard: reg_write dropped, everything else loaded
    drive_id(1'b1, 32'h0000_0104, 5'd0, 10'h203, 1'b0);
    step();
    check_eq("x0_ctrl", {54'd0, ex_ctrl}, 64'h003);
    check_eq("x0_pc", {32'd0, ex_pc}, 64'h104);
    check_eq("x0_rd", {59'd0, ex_rd}, 64'd0);
    check_eq("x0_f3", {61'd0, ex_func3}, 64'd1);
    check_eq("x0_valid", {63'd0, ex_valid}, 64'd1);

    // Invalid ID slot: ctrl/pred zeroed, data still captured
    drive_id(1'b0, 32'h0000_0108, 5'd6, 10'h3FF, 1'b1);
    step();
    check_eq("inv_valid", {63'd0, ex_valid}, 64'd0);
    check_eq("inv_ctrl", {54'd0, ex_ctrl}, 64'd0);
    check_eq("inv_pred", {63'd0, ex_pred_taken}, 64'd0);
    check_eq("inv_pc", {32'd0, ex_pc}, 64'h108);
    check_eq("inv_rd", {59'd0, ex_rd}, 64'd6);

    // Load-use: lw x3 in EX, then en=1 flush=1 inserts one bubble
    drive_id(1'b1, 32'h0000_010C, 5'd3, 10'h360, 1'b0);
    step();
    check_eq("lw_load", {63'd0, ex_load_inst}, 64'd1);
    check_eq("lw_ctrl", {54'd0, ex_ctrl}, 64'h360);
    drive_id(1'b1, 32'h0000_0110, 5'd4, 10'h203, 1'b1);
    id_ex_flush = 1'b1;
    step();
    id_ex_flush = 1'b0;
    check_all_zero("lu");
    check_eq("lu_bubble", {48'd0, bubble_cnt}, 64'd1);
    check_eq("lu_hold", {48'd0, hold_cnt}, 64'd0);

    // Hold for 3 cycles with changing ID inputs
    drive_id(1'b1, 32'h0000_0114, 5'd7, 10'h200, 1'b1);
    step();
    check_eq("pre_hold_pc", {32'd0, ex_pc}, 64'h114);
    id_ex_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_id(1'b1, 32'h0000_0200 + 32'(i * 4), 5'd8, 10'h3FF, 1'b0);
      step();
      check_eq("hold_pc", {32'd0, ex_pc}, 64'h114);
      check_eq("hold_rd", {59'd0, ex_rd}, 64'd7);
      check_eq("hold_ctrl", {54'd0, ex_ctrl}, 64'h200);
      check_eq("hold_valid", {63'd0, ex_valid}, 64'd1);
    end
    check_eq("hold_cnt3", {48'd0, hold_cnt}, 64'd3);
    check_eq("hold_bubble", {48'd0, bubble_cnt}, 64'd1);

    // Flush during stall wins
    id_ex_flush = 1'b1;
    step();
    id_ex_flush = 1'b0;
    check_all_zero("sfl");
    check_eq("sfl_bubble", {48'd0, bubble_cnt}, 64'd2);
    check_eq("sfl_hold", {48'd0, hold_cnt}, 64'd3);

    // Asynchronous reset between edges
    id_ex_en = 1'b1;
    drive_id(1'b1, 32'h0000_0300, 5'd10, 10'h360, 1'b1);
    step();
    check_eq("pre_rst_pc", {32'd0, ex_pc}, 64'h300);
    #2 rst = 1'b1;
    #1;
    check_all_zero("arst");
    check_eq("arst_bubble", {48'd0, bubble_cnt}, 64'd0);
    check_eq("arst_hold", {48'd0, hold_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Saturation: 20 flushes; the 4-bit copy must stop at 15
    id_ex_flush = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 14) check_eq("sat_at15", {60'd0, s_bubble_cnt}, 64'd15);
    end
    id_ex_flush = 1'b0;
    check_eq("sat_small", {60'd0, s_bubble_cnt}, 64'd15);
    check_eq("sat_wide", {48'd0, bubble_cnt}, 64'd20);
    check_eq("sat_hold", {60'd0, s_hold_cnt}, 64'd0);

    // Hold counter saturation on the 4-bit copy
    id_ex_en = 1'b0;
    for (int i = 0; i < 17; i++) step();
    check_eq("sat_hold_small", {60'd0, s_hold_cnt}, 64'd15);
    check_eq("sat_hold_wide", {48'd0, hold_cnt}, 64'd17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
